// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths
// and the port-select encoding used by the round-robin pointer.
package regfile_wb_arbiter_pkg;

  localparam int XLEN_D = 32;
  localparam int AW_D   = 5;
  localparam int NREG_D = 32;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared on accepted writeback,
// with source-register busy lookups for decode stalls.
module wb_scoreboard #(
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_idx,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_idx,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pending_nxt;

  // The set is applied after the clear so a new producer to the same index wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en && (i_clr_idx != '0)) w_pending_nxt[i_clr_idx] = 1'b0;
    if (i_set_en && (i_set_idx != '0)) w_pending_nxt[i_set_idx] = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pending_nxt;
  end

  assign o_rs1_busy = (i_rs1 != '0) && r_pending[i_rs1];
  assign o_rs2_busy = (i_rs2 != '0) && r_pending[i_rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter in front of the register file's single write port,
// with a registered write stage and a pending-writeback scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int AW    = AW_D,
  parameter int NREG  = NREG_D,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_indata,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy
);

  sel_e            r_ptr;
  logic            r_we;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_data;

  logic            w_gnt_a;
  logic            w_gnt_b;
  logic            w_both;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;
  logic            w_wr;

  assign w_both = a_valid && b_valid;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!rst) begin
      if (w_both) begin
        if (RR_EN && (r_ptr == SEL_B)) w_gnt_b = 1'b1;
        else                           w_gnt_a = 1'b1;
      end else begin
        w_gnt_a = a_valid;
        w_gnt_b = b_valid;
      end
    end
  end

  assign a_ready = w_gnt_a;
  assign b_ready = w_gnt_b;

  assign w_rd   = w_gnt_b ? b_rd   : a_rd;
  assign w_data = w_gnt_b ? b_data : a_data;
  assign w_wr   = (w_gnt_a || w_gnt_b) && (w_rd != '0);

  // Pointer only moves on contention, toward the side that just lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= SEL_A;
    end else if (RR_EN && w_both) begin
      r_ptr <= w_gnt_a ? SEL_B : SEL_A;
    end
  end

  // Index/data hold their last written value while the write enable is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_rd   <= w_rd;
        r_data <= w_data;
      end
    end
  end

  assign rf_we     = r_we;
  assign rf_rd     = r_rd;
  assign rf_indata = r_data;

  wb_scoreboard #(
    .AW   (AW),
    .NREG (NREG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (issue_valid),
    .i_set_idx  (issue_rd),
    .i_clr_en   (w_wr),
    .i_clr_idx  (w_rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .o_rs1_busy (rs1_busy),
    .o_rs2_busy (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: one round-robin instance and one
// fixed-priority instance, driven from a single linear stimulus sequence.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1, rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, rf_we, rs1_busy, rs2_busy;
  logic [4:0]  rf_rd;
  logic [31:0] rf_indata;

  logic        fa_valid, fb_valid, f_issue_valid;
  logic [4:0]  fa_rd, fb_rd, f_issue_rd, f_rs1, f_rs2;
  logic [31:0] fa_data, fb_data;
  logic        fa_ready, fb_ready, frf_we, f_rs1_busy, f_rs2_busy;
  logic [4:0]  frf_rd;
  logic [31:0] frf_indata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .AW(5), .NREG(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_indata(rf_indata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  regfile_wb_arbiter #(.XLEN(32), .AW(5), .NREG(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .a_valid(fa_valid), .a_rd(fa_rd), .a_data(fa_data), .a_ready(fa_ready),
    .b_valid(fb_valid), .b_rd(fb_rd), .b_data(fb_data), .b_ready(fb_ready),
    .rf_we(frf_we), .rf_rd(frf_rd), .rf_indata(frf_indata),
    .issue_valid(f_issue_valid), .issue_rd(f_issue_rd),
    .rs1(f_rs1), .rs2(f_rs2), .rs1_busy(f_rs1_busy), .rs2_busy(f_rs2_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  exp_rd [4];
    logic        any_busy;
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
    b_valid = 1'b0; b_rd = '0;   b_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    fa_valid = 1'b0; fa_rd = '0; fa_data = '0;
    fb_valid = 1'b0; fb_rd = '0; fb_data = '0;
    f_issue_valid = 1'b0; f_issue_rd = '0; f_rs1 = '0; f_rs2 = '0;

    // Reset with a request present: nothing accepted, outputs cleared.
    tick(); tick();
    check("rst_a_ready", a_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_rd", rf_rd, 0);
    check("rst_rf_indata", rf_indata, 0);
    any_busy = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      #1;
      any_busy = any_busy | rs1_busy;
    end
    check("rst_rs1_busy_any", any_busy, 0);

    // First write after release.
    rst = 1'b0;
    #1;
    check("first_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("first_rf_we", rf_we, 1);
    check("first_rf_rd", rf_rd, 5);
    check("first_rf_indata", rf_indata, 32'hDEADBEEF);

    // Round-robin contention: A,B,A,B.
    exp_rd[0] = 5'd1; exp_rd[1] = 5'd11; exp_rd[2] = 5'd2; exp_rd[3] = 5'd12;
    a_valid = 1'b1; a_rd = 5'd1;  a_data = 32'h101;
    b_valid = 1'b1; b_rd = 5'd11; b_data = 32'h1011;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr_a_ready_%0d", c), a_ready, (c % 2 == 0) ? 1 : 0);
      check($sformatf("rr_b_ready_%0d", c), b_ready, (c % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("rr_rf_rd_%0d", c), rf_rd, exp_rd[c]);
      check($sformatf("rr_rf_we_%0d", c), rf_we, 1);
      if (c % 2 == 0) begin a_rd = a_rd + 5'd1; a_data = a_data + 32'h1; end
      else            begin b_rd = b_rd + 5'd1; b_data = b_data + 32'h1; end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("rr_rf_indata_last", rf_indata, 32'h1012);

    // Fixed priority: A wins every contended cycle, B waits.
    fa_valid = 1'b1; fa_rd = 5'd2; fa_data = 32'hA0;
    fb_valid = 1'b1; fb_rd = 5'd9; fb_data = 32'hB9;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("fp_a_ready_%0d", c), fa_ready, 1);
      check($sformatf("fp_b_ready_%0d", c), fb_ready, 0);
      tick();
      check($sformatf("fp_rf_rd_%0d", c), frf_rd, 2 + c);
      fa_rd = fa_rd + 5'd1;
    end
    fa_valid = 1'b0;
    #1;
    check("fp_b_ready_after", fb_ready, 1);
    tick();
    fb_valid = 1'b0;
    check("fp_b_rf_we", frf_we, 1);
    check("fp_b_rf_rd", frf_rd, 9);
    check("fp_b_rf_indata", frf_indata, 32'hB9);

    // x0 writes are accepted but never reach the regfile.
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
    #1;
    check("x0_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("x0_rf_we", rf_we, 0);
    check("x0_rf_rd_hold", rf_rd, 12);
    check("x0_rf_indata_hold", rf_indata, 32'h1012);
    rs1 = 5'd0;
    #1;
    check("x0_rs1_busy", rs1_busy, 0);

    // Scoreboard set, clear, and set-wins-over-clear.
    issue_valid = 1'b1; issue_rd = 5'd7;
    rs1 = 5'd7; rs2 = 5'd7;
    #1;
    check("sb_busy_before_issue", rs1_busy, 0);
    tick();
    issue_valid = 1'b0;
    check("sb_rs1_busy_set", rs1_busy, 1);
    check("sb_rs2_busy_set", rs2_busy, 1);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    #1;
    check("sb_busy_during_write", rs1_busy, 1);
    tick();
    a_valid = 1'b0;
    #1;
    check("sb_rs1_busy_cleared", rs1_busy, 0);
    check("sb_rf_rd", rf_rd, 7);
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h78;
    tick();
    issue_valid = 1'b0; a_valid = 1'b0;
    #1;
    check("sb_set_wins", rs1_busy, 1);
    check("sb_set_wins_rf_indata", rf_indata, 32'h78);

    // Reset mid-operation with B waiting and the pointer on B.
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd8;
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd3; rs2 = 5'd8;
    #1;
    check("mid_rs1_busy_pre", rs1_busy, 1);
    check("mid_rs2_busy_pre", rs2_busy, 1);
    a_valid = 1'b1; a_rd = 5'd20; a_data = 32'h20;
    b_valid = 1'b1; b_rd = 5'd21; b_data = 32'h21;
    #1;
    check("mid_contend_a", a_ready, 1);
    tick();
    a_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_b_ready", b_ready, 0);
    tick();
    check("mid_rst_rf_we", rf_we, 0);
    check("mid_rst_rf_rd", rf_rd, 0);
    check("mid_rst_rs1_busy", rs1_busy, 0);
    check("mid_rst_rs2_busy", rs2_busy, 0);
    rst = 1'b0;
    #1;
    check("mid_rel_b_ready", b_ready, 1);
    tick();
    check("mid_rel_rf_rd", rf_rd, 21);
    check("mid_rel_rf_we", rf_we, 1);
    a_valid = 1'b1; a_rd = 5'd22; a_data = 32'h22;
    b_rd = 5'd23; b_data = 32'h23;
    #1;
    check("mid_ptr_reset_a", a_ready, 1);
    check("mid_ptr_reset_b", b_ready, 0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("mid_ptr_rf_rd", rf_rd, 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: port A (ALU/execute writeback) and port B (load/multi-cycle unit writeback).
- Arbitrates with a valid/ready handshake and registers the winning write onto the regfile's rd/indata/we inputs.
- Keeps a per-register pending scoreboard so decode can stall on source registers whose writeback is still in flight.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of writeback values.
- AW, 5, register index width.
- NREG, 32, number of architectural registers (2**AW).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, A over B.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  port A write request.
- a_rd  input  AW  port A destination register.
- a_data  input  XLEN  port A write value.
- a_ready  output  1  port A request accepted this cycle.
- b_valid  input  1  port B write request.
- b_rd  input  AW  port B destination register.
- b_data  input  XLEN  port B write value.
- b_ready  output  1  port B request accepted this cycle.
- rf_we  output  1  register file write enable.
- rf_rd  output  AW  register file write index.
- rf_indata  output  XLEN  register file write data.
- issue_valid  input  1  decode issues an instruction that will write issue_rd.
- issue_rd  input  AW  destination of the issued instruction.
- rs1  input  AW  decode source index 1.
- rs2  input  AW  decode source index 2.
- rs1_busy  output  1  rs1 has a pending writeback.
- rs2_busy  output  1  rs2 has a pending writeback.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rf_we=0, rf_rd=0, rf_indata=0.
  - Pending vector cleared to all zeros.
  - Round-robin pointer set to A.
  - a_ready and b_ready evaluate to 0 while rst=1.
  - rst takes priority over every other event in the same cycle. Requests presented during reset are not accepted.
- Arbitration (combinational grant, at most one per cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid, RR_EN=1: grant the side the pointer names. After the grant, the pointer moves to the other side.
  - Both valid, RR_EN=0: always grant A.
  - Pointer updates only on a cycle where both were valid.
- Handshake:
  - x_ready = grant_x. A transfer occurs when x_valid && x_ready.
  - The requester must hold rd/data stable while valid && !ready.
  - The losing side sees ready=0 and retries next cycle.
  - No internal queue; this block provides no combinational path from rf outputs back to the ready signals.
- Write output (registered, latency 1):
  - The cycle after a transfer with rd!=0: rf_we=1, rf_rd=rd, rf_indata=data.
  - Otherwise rf_we=0. rf_rd/rf_indata hold their previous values when rf_we=0.
  - Transfers with rd=0 are accepted (ready=1) but produce rf_we=0 and do not touch the scoreboard.
- Back-to-back: one write per cycle sustained. Each cycle's grant appears on the rf outputs in the following cycle.
- Scoreboard (pending[NREG-1:0]):
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the edge.
  - Clear: a transfer with rd!=0 clears pending[rd] at the same edge the write is registered.
  - Same index set and cleared in one cycle: the set wins, because a new producer is in flight.
  - pending[0] is always 0.
  - Issue of a register that is already pending leaves it pending.
  - Clearing a non-pending register is harmless.
- Busy outputs:
  - rs1_busy = (rs1!=0) && pending[rs1]; rs2_busy is the same for rs2.
  - Combinational from the current pending state; the same-cycle issue or clear takes effect next cycle.
  - The regfile write lands one cycle after the clear. Decode therefore treats busy=0 as readable only one cycle later, or relies on regfile write-before-read bypass. This block adds no bypass.

Decomposition:
- Shared package:
  - XLEN/AW/NREG defaults.
  - Port-select encoding: SEL_A=1'b0, SEL_B=1'b1.
- One natural sub-module, wb_scoreboard: pending vector, set/clear logic, busy lookups.
- Arbiter and output register stay in the top.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with a_valid=1 -> a_ready=0, rf_we=0, rs1_busy=0 for all rs1; after release, a_rd=5, a_data=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_indata=0xDEADBEEF.
- Contention, RR_EN=1: both valid for 4 cycles (A rd=1..4, B rd=11..14, each held until accepted) -> grants alternate A,B,A,B; rf_rd sequence 1,11,2,12 one cycle delayed.
- Contention, RR_EN=0: both valid for 3 cycles -> a_ready=1, b_ready=0 every cycle; B's rd=9 writes only after a_valid drops.
- x0 filter: b_valid, b_rd=0, b_data=0x1234 -> b_ready=1; next cycle rf_we=0; pending unchanged.
- Scoreboard: issue rd=7 -> next cycle rs1=7 gives rs1_busy=1; a write to rd=7 accepted -> busy=0 the following cycle. Issue rd=7 and write rd=7 in the same cycle -> stays busy.
- Reset mid-operation: pending={3,8}, B held waiting -> rst pulse clears pending (rs busy=0 for 3 and 8), rf_we=0, no transfer during reset; after release, B is granted first.
